i2s_to_wb_wbm_arbiter: RTL
==========================

Name: i2s_to_wb_wbm_arbiter

Overview:
Two-requester Wishbone master arbiter that shares one external Wishbone master port between the right and left TX DMA engines of the I2S-to-Wishbone transmit path.
Requester 0 is the right-channel DMA; requester 1 is the left-channel DMA.
Arbitration is round-robin with the grant locked for a whole bus cycle (cyc high).
The block sits between the two i2s_to_wb_tx_dma instances and the system Wishbone fabric.

Parameters:
ARB_TIMEOUT_CYCLES, 255, cycles a granted strobe may wait for ack/err/rty before forced termination (used only with the optional feature); range 1..255.

Ports:
i2s_clk_i  in  1  block clock
i2s_rst_i  in  1  reset: synchronous, active-high
arb_enable  in  1  when low, no new grant is issued; an in-flight cycle completes
req_cyc_i  in  2  requester cyc; bit n belongs to requester n
req_stb_i  in  2  requester stb
req_we_i  in  2  requester we
req_sel_i  in  8  requester sel; [4n+3:4n] belongs to requester n
req_addr_i  in  64  requester address; [32n+31:32n] belongs to requester n
req_data_i  in  64  requester write data; same packing as req_addr_i
req_data_o  out  32  read data, broadcast to both requesters (= wbm_data_i)
req_ack_o  out  2  ack, routed to the granted requester only
req_err_o  out  2  err, routed to the granted requester only
req_rty_o  out  2  rty, routed to the granted requester only
wbm_data_o  out  32  muxed write data
wbm_addr_o  out  32  muxed address
wbm_sel_o  out  4  muxed sel
wbm_we_o  out  1  muxed we
wbm_cyc_o  out  1  muxed cyc
wbm_stb_o  out  1  muxed stb
wbm_data_i  in  32  slave read data
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave err
wbm_rty_i  in  1  slave rty
grant_o  out  2  one-hot current grant; 00 when idle
arb_timeout_error  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Registered state; grant_o is decoded from the state.
- Reset: state=IDLE, last_grant=1 (so requester 0 wins the first tie), grant_o=00, arb_timeout_error=0.
  - All wbm_* outputs are 0 while IDLE.
  - All req_ack_o/req_err_o/req_rty_o are 00 while IDLE.
  - Reset asserted mid-cycle drops wbm_cyc_o/wbm_stb_o on the next edge.
- IDLE -> GNTn when arb_enable=1 and req_cyc_i[n]=1:
  - If only one requester asserts cyc, it is granted.
  - If both assert cyc, the one not equal to last_grant is granted.
  - last_grant is updated to n on entry to GNTn.
- Latency: req_cyc_i asserted in cycle N (state IDLE) -> grant_o and wbm_cyc_o asserted in cycle N+1.
- In GNTn:
  - wbm_{cyc,stb,we,sel,addr,data}_o = requester n's inputs, combinationally.
  - req_ack_o[n]=wbm_ack_i, req_err_o[n]=wbm_err_i, req_rty_o[n]=wbm_rty_i.
  - The other requester's ack/err/rty are held at 0.
- GNTn -> IDLE when req_cyc_i[n]=0 (sampled at the clock edge). The bus is released for at least one cycle, and the other requester may be granted in the cycle after that.
- A non-granted requester holding cyc simply waits; no timeout applies to waiting requesters.
- arb_enable has no effect once a grant is held. Deasserting it while both requesters are pending leaves the FSM in IDLE.
- Wait states: the granted requester may hold stb high for any number of cycles until ack/err/rty. Multiple stb/ack beats within one cyc stay on the same grant (block transfers are not interrupted).

Optional Feature:
Macro I2S_TO_WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter resets to 0 on every cycle that is not (GNTn & wbm_stb_o & ~wbm_ack_i & ~wbm_err_i & ~wbm_rty_i), and increments otherwise.
  - When the counter equals ARB_TIMEOUT_CYCLES:
    - req_err_o[n] is driven 1 for that single cycle.
    - wbm_cyc_o and wbm_stb_o are forced 0 for that cycle.
    - arb_timeout_error is set (sticky).
    - The FSM goes to IDLE at the next edge regardless of req_cyc_i[n], and the counter is cleared.
- Not defined: no counter is present, arb_timeout_error is tied 0, and a hung slave holds the grant indefinitely.

Test Plan:
- Reset, then requester 0 raises cyc/stb with addr 0x100; slave acks 2 cycles later -> grant_o=01 from the next cycle, wbm_addr_o=0x100, req_ack_o=01 in the ack cycle, grant_o=00 one edge after cyc drops.
- Both requesters raise cyc in the same cycle after reset -> requester 0 is granted first; after it releases, requester 1 is granted with grant_o=10 exactly 2 cycles after cyc0 falls; requester 1 never sees an ack.
- Requester 1 performs a 4-beat read while requester 0 requests -> the grant stays 10 across all 4 beats and wbm_data_i reaches req_data_o each beat; requester 0 is granted afterwards.
- Hold arb_enable=0 with both requesters pending for 10 cycles -> grant_o=00 and wbm_cyc_o=0 throughout; arb_enable=1 -> grant issued the next cycle.
- Assert reset in the middle of a granted cycle -> grant_o=00 and wbm_cyc_o=0 after the edge; last_grant=1, so on a subsequent tie requester 0 wins.
- With I2S_TO_WB_ARB_TIMEOUT_EN and ARB_TIMEOUT_CYCLES=8, slave never responds -> req_err_o[n] pulses once 8 cycles after stb, arb_timeout_error=1 and remains set, grant_o returns to 00; without the macro, arb_timeout_error stays 0.

Source files
------------

// File: rtl/i2s_to_wb_wbm_arbiter.sv
// Round-robin Wishbone master arbiter sharing one bus between the right (0) and left (1) TX DMA engines.
// Optional strobe watchdog enabled by defining I2S_TO_WB_ARB_TIMEOUT_EN.
module i2s_to_wb_wbm_arbiter #(
  parameter int ARB_TIMEOUT_CYCLES = 255
) (
  input  logic        i2s_clk_i,
  input  logic        i2s_rst_i,
  input  logic        arb_enable,
  input  logic [1:0]  req_cyc_i,
  input  logic [1:0]  req_stb_i,
  input  logic [1:0]  req_we_i,
  input  logic [7:0]  req_sel_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_data_i,
  output logic [31:0] req_data_o,
  output logic [1:0]  req_ack_o,
  output logic [1:0]  req_err_o,
  output logic [1:0]  req_rty_o,
  output logic [31:0] wbm_data_o,
  output logic [31:0] wbm_addr_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [1:0]  grant_o,
  output logic        arb_timeout_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   granted, gidx, tmo;

  if (ARB_TIMEOUT_CYCLES < 1 || ARB_TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("ARB_TIMEOUT_CYCLES must be in 1..255");
  end

  assign granted = (state_q != IDLE);
  assign gidx    = (state_q == GNT1);
  assign grant_o = {state_q == GNT1, state_q == GNT0};

  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Tie goes to the requester that was not granted last; grant held until its cyc drops.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (arb_enable) begin
          if (req_cyc_i[0] && (!req_cyc_i[1] || last_grant_q)) begin
            state_d      = GNT0;
            last_grant_d = 1'b0;
          end else if (req_cyc_i[1]) begin
            state_d      = GNT1;
            last_grant_d = 1'b1;
          end
        end
      end
      GNT0:    if (tmo || !req_cyc_i[0]) state_d = IDLE;
      GNT1:    if (tmo || !req_cyc_i[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_data_o = wbm_data_i;

  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = '0;
    wbm_addr_o = '0;
    wbm_data_o = '0;
    req_ack_o  = '0;
    req_err_o  = '0;
    req_rty_o  = '0;
    if (granted) begin
      wbm_cyc_o       = req_cyc_i[gidx] & ~tmo;
      wbm_stb_o       = req_stb_i[gidx] & ~tmo;
      wbm_we_o        = req_we_i[gidx];
      wbm_sel_o       = req_sel_i[{gidx, 2'b00} +: 4];
      wbm_addr_o      = req_addr_i[{gidx, 5'b00000} +: 32];
      wbm_data_o      = req_data_i[{gidx, 5'b00000} +: 32];
      req_ack_o[gidx] = wbm_ack_i;
      req_err_o[gidx] = wbm_err_i | tmo;
      req_rty_o[gidx] = wbm_rty_i;
    end
  end

`ifdef I2S_TO_WB_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       stall;

  // Counts consecutive cycles the granted strobe is outstanding with no slave response.
  assign stall = granted && req_stb_i[gidx] && !wbm_ack_i && !wbm_err_i && !wbm_rty_i;
  assign tmo   = granted && (tmo_cnt_q == 8'(ARB_TIMEOUT_CYCLES));

  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i) begin
      tmo_cnt_q         <= '0;
      arb_timeout_error <= 1'b0;
    end else begin
      tmo_cnt_q <= (stall && !tmo) ? tmo_cnt_q + 8'd1 : 8'd0;
      if (tmo) arb_timeout_error <= 1'b1;
    end
  end
`else
  assign tmo               = 1'b0;
  assign arb_timeout_error = 1'b0;
`endif

endmodule
